hazard_stall_unit: RTL and testbench

Control-side companion of the forwarding path in the 16-bit pipelined processor. Forwarding resolves hazards by steering data; this unit covers the hazards forwarding cannot resolve. It detects load-use hazards, multi-cycle memory waits and taken branches, and drives the pipeline-register write enables, bubbles and flushes. It also keeps saturating stall/flush statistics for debug.

---
 rtl/hazard_stall_unit_pkg.sv | 16 +
 rtl/hazard_stall_unit_sat_counter.sv | 22 ++
 rtl/hazard_stall_unit.sv | 125 ++++++++++++
 tb/tb_hazard_stall_unit.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/hazard_stall_unit_pkg.sv
// Shared definitions for the hazard/stall control unit and the pipeline registers it drives.
package hazard_stall_unit_pkg;

    typedef enum logic {
        ST_RUN      = 1'b0,
        ST_MEM_WAIT = 1'b1
    } state_t;

    localparam int REG_AW = 4;
    localparam logic [REG_AW-1:0] ZERO_REG = '0;

    // Encoding the pipeline registers load when flushed or bubbled.
    localparam int INSTR_W = 16;
    localparam logic [INSTR_W-1:0] NOP_INSTR = 16'h0000;

endpackage

// File: rtl/hazard_stall_unit_sat_counter.sv
// Saturating up-counter with a synchronous clear that wins over the increment.
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         inc,
    input  logic         clr,
    output logic [W-1:0] count
);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/hazard_stall_unit.sv
// Stall/flush control for hazards the forwarding path cannot resolve:
// load-use, multi-cycle memory waits and taken branches, plus debug statistics.
module hazard_stall_unit #(
    parameter int REG_AW   = hazard_stall_unit_pkg::REG_AW,
    parameter int MAX_WAIT = 255,
    parameter int CNT_W    = 16
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [REG_AW-1:0] id_rs1,
    input  logic [REG_AW-1:0] id_rs2,
    input  logic              id_uses_rs1,
    input  logic              id_uses_rs2,
    input  logic [REG_AW-1:0] ex_rd,
    input  logic              ex_memread,
    input  logic              ex_branch_taken,
    input  logic              mem_req,
    input  logic              mem_ack,
    input  logic              stat_clear,
    output logic              pc_write,
    output logic              ifid_write,
    output logic              idex_write,
    output logic              exmem_write,
    output logic              ifid_flush,
    output logic              idex_bubble,
    output logic              mem_timeout,
    output logic [CNT_W-1:0]  stall_cycles,
    output logic [CNT_W-1:0]  flush_count
);
    import hazard_stall_unit_pkg::*;

    localparam logic [7:0] WAIT_LIMIT = 8'(MAX_WAIT);

    state_t     state;
    state_t     next_state;
    logic [7:0] wait_cnt;
    logic [7:0] wait_next;
    logic       load_use;
    logic       mem_hold;
    logic       freeze;

    assign load_use = ex_memread && (ex_rd != REG_AW'(ZERO_REG)) &&
                      ((id_uses_rs1 && (ex_rd == id_rs1)) ||
                       (id_uses_rs2 && (ex_rd == id_rs2)));
    assign mem_hold = mem_req && !mem_ack;
    // The ack cycle of a wait is not frozen, so a held branch can flush on release.
    assign freeze   = (state == ST_MEM_WAIT) ? !mem_ack : mem_hold;

    always_comb begin
        next_state  = state;
        pc_write    = 1'b1;
        ifid_write  = 1'b1;
        idex_write  = 1'b1;
        exmem_write = 1'b1;
        ifid_flush  = 1'b0;
        idex_bubble = 1'b0;

        case (state)
            ST_RUN:      if (mem_hold) next_state = ST_MEM_WAIT;
            ST_MEM_WAIT: if (mem_ack)  next_state = ST_RUN;
            default:     next_state = ST_RUN;
        endcase

        if (reset) begin
            pc_write    = 1'b0;
            ifid_write  = 1'b0;
            idex_write  = 1'b0;
            exmem_write = 1'b0;
            idex_bubble = 1'b1;
        end else if (freeze) begin
            pc_write    = 1'b0;
            ifid_write  = 1'b0;
            idex_write  = 1'b0;
            exmem_write = 1'b0;
        end else if (ex_branch_taken) begin
            ifid_flush  = 1'b1;
            idex_bubble = 1'b1;
        end else if (load_use) begin
            pc_write    = 1'b0;
            ifid_write  = 1'b0;
            idex_bubble = 1'b1;
        end
    end

    always_comb begin
        wait_next = '0;
        if (state == ST_MEM_WAIT) begin
            wait_next = wait_cnt;
            if (!mem_ack && (wait_cnt != WAIT_LIMIT)) begin
                wait_next = wait_cnt + 8'd1;
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state       <= ST_RUN;
            wait_cnt    <= '0;
            mem_timeout <= 1'b0;
        end else begin
            state    <= next_state;
            wait_cnt <= wait_next;
            if ((state == ST_MEM_WAIT) && (wait_next == WAIT_LIMIT)) begin
                mem_timeout <= 1'b1;
            end
        end
    end

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clock (clock),
        .reset (reset),
        .inc   (!pc_write && !reset),
        .clr   (stat_clear),
        .count (stall_cycles)
    );

    sat_counter #(.W(CNT_W)) u_flush_cnt (
        .clock (clock),
        .reset (reset),
        .inc   (ifid_flush),
        .clr   (stat_clear),
        .count (flush_count)
    );

endmodule

// File: tb/tb_hazard_stall_unit.sv
// Directed bench for hazard_stall_unit: expected values are queued when stimulus is applied and checked as outputs appear.
module tb_hazard_stall_unit;

    localparam int CNT_W = 16;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    // ctrl = {pc_write, ifid_write, idex_write, exmem_write, ifid_flush, idex_bubble}
    localparam logic [5:0] C_RESET  = 6'b000001;
    localparam logic [5:0] C_RUN    = 6'b111100;
    localparam logic [5:0] C_FREEZE = 6'b000000;
    localparam logic [5:0] C_BRANCH = 6'b111111;
    localparam logic [5:0] C_LU     = 6'b001101;

    logic             clock = 1'b0;
    logic             reset = 1'b1;
    logic [3:0]       id_rs1 = '0, id_rs2 = '0, ex_rd = '0;
    logic             id_uses_rs1 = 1'b0, id_uses_rs2 = 1'b0;
    logic             ex_memread = 1'b0, ex_branch_taken = 1'b0;
    logic             mem_req = 1'b0, mem_ack = 1'b0, stat_clear = 1'b0;
    logic             pc_write, ifid_write, idex_write, exmem_write;
    logic             ifid_flush, idex_bubble, mem_timeout;
    logic [CNT_W-1:0] stall_cycles, flush_count;
    logic [5:0]       ctrl;

    typedef struct {
        string       tag;
        logic [31:0] val;
    } exp_t;

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;
    int   exp_stall = 0;
    int   exp_flush = 0;

    always #5 clock = ~clock;

    assign ctrl = {pc_write, ifid_write, idex_write, exmem_write, ifid_flush, idex_bubble};

    hazard_stall_unit #(.REG_AW(4), .MAX_WAIT(8), .CNT_W(CNT_W)) dut (
        .clock           (clock),
        .reset           (reset),
        .id_rs1          (id_rs1),
        .id_rs2          (id_rs2),
        .id_uses_rs1     (id_uses_rs1),
        .id_uses_rs2     (id_uses_rs2),
        .ex_rd           (ex_rd),
        .ex_memread      (ex_memread),
        .ex_branch_taken (ex_branch_taken),
        .mem_req         (mem_req),
        .mem_ack         (mem_ack),
        .stat_clear      (stat_clear),
        .pc_write        (pc_write),
        .ifid_write      (ifid_write),
        .idex_write      (idex_write),
        .exmem_write     (exmem_write),
        .ifid_flush      (ifid_flush),
        .idex_bubble     (idex_bubble),
        .mem_timeout     (mem_timeout),
        .stall_cycles    (stall_cycles),
        .flush_count     (flush_count)
    );

    task automatic pushExpected(input string tag, input logic [31:0] val);
        exp_t e;
        e.tag = tag;
        e.val = val;
        sb.push_back(e);
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed);
        exp_t e;
        checks++;
        if (sb.size() == 0) begin
            errors++;
            $error("[TB] FAIL %s: observed %0h but no expected value queued", tag, observed);
            return;
        end
        e = sb.pop_front();
        assert (observed === e.val)
        else begin
            errors++;
            $error("[TB] FAIL %s (%s): observed %0h expected %0h", tag, e.tag, observed, e.val);
        end
    endtask

    task automatic applyStimulus(input logic [3:0] rs1, input logic [3:0] rs2,
                                 input logic u1, input logic u2, input logic [3:0] rd,
                                 input logic memread, input logic br,
                                 input logic req, input logic ack);
        @(negedge clock);
        id_rs1          = rs1;
        id_rs2          = rs2;
        id_uses_rs1     = u1;
        id_uses_rs2     = u2;
        ex_rd           = rd;
        ex_memread      = memread;
        ex_branch_taken = br;
        mem_req         = req;
        mem_ack         = ack;
    endtask

    // Checks the combinational controls, clocks once, then checks the statistics.
    task automatic runCycle(input string tag, input logic [5:0] exp_ctrl);
        pushExpected(tag, 32'(exp_ctrl));
        #1;
        checkOutput({tag, ".ctrl"}, 32'(ctrl));
        @(posedge clock);
        #1;
        if (stat_clear) begin
            exp_stall = 0;
            exp_flush = 0;
        end else begin
            if (!exp_ctrl[5] && exp_stall < CNT_MAX) exp_stall++;
            if (exp_ctrl[1] && exp_flush < CNT_MAX) exp_flush++;
        end
        pushExpected(tag, 32'(exp_stall));
        checkOutput({tag, ".stall"}, 32'(stall_cycles));
        pushExpected(tag, 32'(exp_flush));
        checkOutput({tag, ".flush"}, 32'(flush_count));
    endtask

    task automatic checkScalar(input string tag, input logic [31:0] observed, input logic [31:0] required);
        pushExpected(tag, required);
        checkOutput(tag, observed);
    endtask

    initial begin
        #2;
        checkScalar("reset.ctrl", 32'(ctrl), 32'(C_RESET));
        checkScalar("reset.stall", 32'(stall_cycles), 32'd0);
        checkScalar("reset.flush", 32'(flush_count), 32'd0);
        checkScalar("reset.timeout", 32'(mem_timeout), 32'd0);

        applyStimulus(4'd0, 4'd0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        reset = 1'b0;
        runCycle("idle", C_RUN);

        // Load-use on rs2, then released the following cycle
        applyStimulus(4'd5, 4'd3, 1'b1, 1'b1, 4'd3, 1'b1, 1'b0, 1'b0, 1'b0);
        runCycle("lu_rs2", C_LU);
        applyStimulus(4'd0, 4'd0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        runCycle("lu_release", C_RUN);
        applyStimulus(4'd0, 4'd0, 1'b1, 1'b1, 4'd0, 1'b1, 1'b0, 1'b0, 1'b0);
        runCycle("lu_r0", C_RUN);
        applyStimulus(4'd7, 4'd2, 1'b0, 1'b1, 4'd7, 1'b1, 1'b0, 1'b0, 1'b0);
        runCycle("lu_rs1_unused", C_RUN);
        applyStimulus(4'd7, 4'd2, 1'b1, 1'b0, 4'd7, 1'b1, 1'b0, 1'b0, 1'b0);
        runCycle("lu_rs1", C_LU);
        applyStimulus(4'd7, 4'd2, 1'b1, 1'b1, 4'd7, 1'b0, 1'b0, 1'b0, 1'b0);
        runCycle("no_load", C_RUN);

        // Four-cycle memory wait, ack on the fifth
        for (int i = 0; i < 4; i++) begin
            applyStimulus(4'd0, 4'd0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b1, 1'b0);
            runCycle("mem_wait", C_FREEZE);
            if (i == 1) checkScalar("mem_wait.state", 32'(dut.state), 32'd1);
        end
        applyStimulus(4'd0, 4'd0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b1, 1'b1);
        runCycle("mem_ack", C_RUN);
        checkScalar("mem_ack.state", 32'(dut.state), 32'd0);

        applyStimulus(4'd0, 4'd0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1);
        runCycle("stray_ack", C_RUN);
        checkScalar("stray_ack.state", 32'(dut.state), 32'd0);

        applyStimulus(4'd1, 4'd3, 1'b1, 1'b1, 4'd3, 1'b1, 1'b1, 1'b0, 1'b0);
        runCycle("branch_over_lu", C_BRANCH);

        // Branch held in EX across a three-cycle wait
        for (int i = 0; i < 3; i++) begin
            applyStimulus(4'd0, 4'd0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b1, 1'b1, 1'b0);
            runCycle("branch_wait", C_FREEZE);
        end
        applyStimulus(4'd0, 4'd0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b1, 1'b1, 1'b1);
        runCycle("branch_release", C_BRANCH);
        applyStimulus(4'd0, 4'd0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        runCycle("after_branch", C_RUN);

        // Timeout with MAX_WAIT=8 and a ten-cycle hold
        for (int i = 1; i <= 10; i++) begin
            applyStimulus(4'd0, 4'd0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b1, 1'b0);
            runCycle("timeout_wait", C_FREEZE);
            if (i == 7) checkScalar("timeout.early", 32'(mem_timeout), 32'd0);
        end
        checkScalar("timeout.set", 32'(mem_timeout), 32'd1);
        applyStimulus(4'd0, 4'd0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b1, 1'b1);
        runCycle("timeout_ack", C_RUN);
        checkScalar("timeout.sticky", 32'(mem_timeout), 32'd1);

        // Asynchronous reset in the middle of a wait
        for (int i = 0; i < 2; i++) begin
            applyStimulus(4'd0, 4'd0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b1, 1'b0);
            runCycle("pre_reset_wait", C_FREEZE);
        end
        #2;
        reset   = 1'b1;
        mem_ack = 1'b1;
        #1;
        exp_stall = 0;
        exp_flush = 0;
        checkScalar("async_reset.ctrl", 32'(ctrl), 32'(C_RESET));
        checkScalar("async_reset.state", 32'(dut.state), 32'd0);
        checkScalar("async_reset.stall", 32'(stall_cycles), 32'd0);
        checkScalar("async_reset.timeout", 32'(mem_timeout), 32'd0);
        applyStimulus(4'd0, 4'd0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1);
        reset = 1'b0;
        runCycle("post_reset", C_RUN);
        checkScalar("post_reset.state", 32'(dut.state), 32'd0);

        // Clear beats a same-cycle increment
        applyStimulus(4'd5, 4'd3, 1'b1, 1'b1, 4'd3, 1'b1, 1'b0, 1'b0, 1'b0);
        runCycle("lu_before_clr", C_LU);
        applyStimulus(4'd5, 4'd3, 1'b1, 1'b1, 4'd3, 1'b1, 1'b1, 1'b0, 1'b0);
        stat_clear = 1'b1;
        runCycle("clr_with_inc", C_BRANCH);
        stat_clear = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
